// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

    localparam int unsigned IF_ADDR_W   = 32;
    localparam int unsigned IF_DATA_W   = 32;
    localparam int unsigned IF_RESET_PC = 0;
    localparam int unsigned IF_PC_INC   = 4;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_HOLD = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, runs one req/ack fetch at a time and holds the
// fetched instruction until the pipeline advances, branches or is reset.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned       ADDR_W   = IF_ADDR_W,
    parameter int unsigned       DATA_W   = IF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC),
    parameter int unsigned       PC_INC   = IF_PC_INC
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              pc_write_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_data_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              fetch_stall_o
);

    if_state_e         r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_buf;
    logic              r_redir_pend;
    logic [ADDR_W-1:0] r_redir_tgt;

    if_state_e         w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [DATA_W-1:0] w_buf_nxt;
    logic              w_redir_pend_nxt;
    logic [ADDR_W-1:0] w_redir_tgt_nxt;
    logic              w_branch;

    // A frozen pipeline cannot issue a redirect.
    assign w_branch = branch_i & ~stall_i;

    // Next-state, PC mux and one-entry buffer.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_buf_nxt        = r_buf;
        w_redir_pend_nxt = r_redir_pend;
        w_redir_tgt_nxt  = r_redir_tgt;

        case (r_state)
            IF_IDLE: begin
                if (start_i) begin
                    w_state_nxt = IF_REQ;
                end
            end

            IF_REQ: begin
                if (imem_ack_i) begin
                    if (!r_redir_pend && !w_branch) begin
                        w_buf_nxt   = imem_data_i;
                        w_state_nxt = IF_HOLD;
                    end else begin
                        // Stale fetch retired: refetch from the newest redirect target.
                        w_pc_nxt         = w_branch ? branch_target_i : r_redir_tgt;
                        w_redir_pend_nxt = 1'b0;
                    end
                end else if (w_branch) begin
                    w_redir_tgt_nxt  = branch_target_i;
                    w_redir_pend_nxt = 1'b1;
                end
            end

            IF_HOLD: begin
                if (!stall_i) begin
                    if (branch_i) begin
                        w_pc_nxt    = branch_target_i;
                        w_state_nxt = IF_REQ;
                    end else if (pc_write_i) begin
                        w_pc_nxt    = r_pc + ADDR_W'(PC_INC);
                        w_state_nxt = IF_REQ;
                    end
                end
            end

            default: begin
                w_state_nxt = IF_IDLE;
            end
        endcase
    end

    // State and registered outputs, decoded from next-state values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= IF_IDLE;
            r_pc          <= RESET_PC;
            r_buf         <= '0;
            r_redir_pend  <= 1'b0;
            r_redir_tgt   <= '0;
            imem_req_o    <= 1'b0;
            imem_addr_o   <= '0;
            pc_o          <= RESET_PC;
            inst_o        <= '0;
            inst_valid_o  <= 1'b0;
            fetch_stall_o <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_buf         <= w_buf_nxt;
            r_redir_pend  <= w_redir_pend_nxt;
            r_redir_tgt   <= w_redir_tgt_nxt;
            imem_req_o    <= (w_state_nxt == IF_REQ);
            imem_addr_o   <= (w_state_nxt == IF_REQ) ? w_pc_nxt : '0;
            pc_o          <= w_pc_nxt;
            inst_o        <= (w_state_nxt == IF_HOLD) ? w_buf_nxt : '0;
            inst_valid_o  <= (w_state_nxt == IF_HOLD);
            fetch_stall_o <= (w_state_nxt == IF_REQ);
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random traffic, with a
// queue of expected delivered PCs checked by an independent monitor.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        stall_i;
    logic        pc_write_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        fetch_stall_o;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] q[$];
    logic [31:0] m_pc      = 32'h0;
    bit          m_started = 1'b0;

    int fixed_lat = 0;
    bit force_ack = 1'b0;
    bit mem_ack   = 1'b0;
    int mem_cnt   = -1;

    if_fetch_unit dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .start_i         (start_i),
        .stall_i         (stall_i),
        .pc_write_i      (pc_write_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .pc_o            (pc_o),
        .inst_o          (inst_o),
        .inst_valid_o    (inst_valid_o),
        .fetch_stall_o   (fetch_stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction memory: fixed or random latency, one-cycle ack pulse.
    always @(negedge clk) begin
        if (!rst_n || !imem_req_o) begin
            mem_ack = 1'b0;
            mem_cnt = -1;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            mem_cnt = -1;
        end else begin
            if (mem_cnt < 0) mem_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            if (mem_cnt == 0) begin
                mem_ack     = 1'b1;
                imem_data_i = mem_word(imem_addr_o);
            end else begin
                mem_cnt--;
            end
        end
        imem_ack_i = mem_ack | force_ack;
    end

    // Monitor: every new instruction presentation pops one expected PC.
    logic        prev_valid = 1'b0;
    logic        prev_req   = 1'b0;
    logic [31:0] prev_addr  = 32'h0;
    always @(posedge clk) begin
        logic [31:0] e;
        #1;
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_req   = 1'b0;
        end else begin
            if (inst_valid_o && !prev_valid) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_inst: got pc %h expected none", pc_o);
                end else begin
                    e = q.pop_front();
                    chk("inst_pc", pc_o, e);
                    chk("inst_data", inst_o, mem_word(e));
                end
            end
            if (!inst_valid_o) chk("inst_zero", inst_o, 32'h0);
            if (prev_req && imem_req_o && !imem_ack_i) chk("addr_stable", imem_addr_o, prev_addr);
            prev_valid = inst_valid_o;
            prev_req   = imem_req_o;
            prev_addr  = imem_addr_o;
        end
    end

    // Drive one cycle of inputs at a negedge and advance the reference model.
    task automatic cyc(input logic st, input logic sl, input logic pw, input logic br,
                       input logic [31:0] tg);
        start_i         = st;
        stall_i         = sl;
        pc_write_i      = pw;
        branch_i        = br;
        branch_target_i = tg;
        if (st && !m_started) begin
            m_started = 1'b1;
            q.push_back(m_pc);
        end else if (m_started && !sl) begin
            if (inst_valid_o) begin
                if (br) begin
                    m_pc = tg;
                    q.push_back(m_pc);
                end else if (pw) begin
                    m_pc = m_pc + 32'd4;
                    q.push_back(m_pc);
                end
            end else if (fetch_stall_o && br) begin
                m_pc = tg;
                if (q.size() > 0) q[q.size()-1] = m_pc;
                else q.push_back(m_pc);
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_valid(input string nm);
        int i = 0;
        while (!inst_valid_o && i < 60) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            i++;
        end
        chk(nm, 32'(inst_valid_o), 32'h1);
    endtask

    task automatic model_reset();
        q.delete();
        m_pc      = 32'h0;
        m_started = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        start_i         = 1'b0;
        stall_i         = 1'b0;
        pc_write_i      = 1'b0;
        branch_i        = 1'b0;
        branch_target_i = 32'h0;
        imem_ack_i      = 1'b0;
        imem_data_i     = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset, then start.
        repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("idle_req", 32'(imem_req_o), 32'h0);
        chk("idle_pc", pc_o, 32'h0);
        chk("idle_inst", inst_o, 32'h0);
        chk("idle_valid", 32'(inst_valid_o), 32'h0);
        chk("idle_fstall", 32'(fetch_stall_o), 32'h0);
        fixed_lat = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("start_req", 32'(imem_req_o), 32'h1);
        chk("start_addr", imem_addr_o, 32'h0);
        chk("start_fstall", 32'(fetch_stall_o), 32'h1);

        // Zero-wait sequential fetches, one HOLD cycle each.
        for (int k = 0; k < 3; k++) begin
            wait_valid("s2_valid");
            chk("s2_pc", pc_o, 32'(k * 4));
            if (k == 2) fixed_lat = 3;
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            chk("s2_one_cycle", 32'(inst_valid_o), 32'h0);
        end
        for (int j = 0; j < 3; j++) begin
            chk("s2_late_req", 32'(imem_req_o), 32'h1);
            chk("s2_late_addr", imem_addr_o, 32'hC);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        wait_valid("s2_late_valid");
        chk("s2_late_pc", pc_o, 32'hC);

        // Hold at 0x10; stalled branch ignored.
        fixed_lat = 0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        wait_valid("s3_valid");
        for (int j = 0; j < 4; j++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            chk("s3_hold_pc", pc_o, 32'h10);
            chk("s3_hold_inst", inst_o, mem_word(32'h10));
            chk("s3_hold_valid", 32'(inst_valid_o), 32'h1);
        end
        for (int j = 0; j < 2; j++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
            chk("s3_stall_pc", pc_o, 32'h10);
            chk("s3_stall_valid", 32'(inst_valid_o), 32'h1);
        end

        // Branch during an in-flight fetch of 0x14.
        fixed_lat = 2;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("s4_req_addr", imem_addr_o, 32'h14);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
        chk("s4_addr_kept", imem_addr_o, 32'h14);
        wait_valid("s4_valid");
        chk("s4_pc", pc_o, 32'h80);

        // PC wrap, then branch beats advance.
        fixed_lat = 0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        wait_valid("s5_top_valid");
        chk("s5_top_pc", pc_o, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("s5_wrap_addr", imem_addr_o, 32'h0);
        wait_valid("s5_wrap_valid");
        chk("s5_wrap_pc", pc_o, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
        wait_valid("s5_br_valid");
        chk("s5_br_pc", pc_o, 32'h40);

        // Reset with a fetch outstanding; stray acks ignored.
        fixed_lat = 5;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("s6_pending_req", 32'(imem_req_o), 32'h1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("s6_rst_req", 32'(imem_req_o), 32'h0);
        force_ack = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("s6_req", 32'(imem_req_o), 32'h0);
        chk("s6_pc", pc_o, 32'h0);
        chk("s6_valid", 32'(inst_valid_o), 32'h0);
        chk("s6_inst", inst_o, 32'h0);
        force_ack = 1'b0;

        // Random traffic against the reference model.
        fixed_lat = -1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int n = 0; n < 800; n++) begin
            logic        sl;
            logic        pw;
            logic        br;
            logic [31:0] tg;
            sl = ($urandom_range(0, 4) == 0);
            pw = ($urandom_range(0, 1) == 1);
            br = ($urandom_range(0, 6) == 0);
            tg = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            cyc(1'b0, sl, pw, br, tg);
        end
        repeat (8) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("end_queue_bound", 32'(q.size() <= 1), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
